cnn_conv_engine: RTL and testbench
==================================

// Module: cnn_conv_engine
// PURPOSE
//   Layer-1 engine of the CNN pipeline: 2-D valid convolution of an 8x8 signed image with a fixed 3x3 kernel,
//   producing a 6x6 feature map. A single sequential MAC (one multiply per clock) feeds the pool layer,
//   which reads output_ram once done is high. Layer-1 sequencing is handled by the top-level FSM.
// PARAMETERS
//   DATA_W   32          pixel / output width, signed
//   IMG_DIM  8           input image side
//   K_DIM    3           kernel side; output side OUT_DIM = IMG_DIM-K_DIM+1 = 6
//   W_W      8           kernel weight width, signed
//   KERNEL   72'h...     9 packed weights, W[0] in bits [7:0], row-major; default {1,0,-1, 1,0,-1, 1,0,-1}
// PORTS
//   clk         in   1            clock, rising edge
//   rst         in   1            reset: synchronous, active-high
//   start       in   1            run request, rising-edge triggered (may be held high)
//   input_ram   in   32 x [0:63]  image, index r*8+c, signed; must be held stable while busy
//   busy        out  1            high while convolution is in progress
//   done        out  1            high from completion until next accepted start
//   output_ram  out  32 x [0:35]  feature map, index r*6+c, signed, registered
// BEHAVIOUR
//   - Reset (sync, active-high): state=IDLE, busy=0, done=0, all output_ram=0, acc=0, start_q=0.
//   - start_q registers start each cycle; an accepted start is start=1 && start_q=0, in IDLE or DONE only.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE -accepted start-> RUN ; RUN -last MAC-> DONE ; DONE -accepted start-> RUN (done cleared same edge).
//   - Entry to RUN: out_idx=0, k=0, acc=0, busy=1, done=0.
//   - Each RUN cycle, with (r,c)=(out_idx/6, out_idx%6) and (kr,kc)=(k/3, k%3):
//     acc_next = acc + input_ram[(r+kr)*8 + c+kc] * W[k].
//   - When k==8: output_ram[out_idx] <= result(acc_next), acc<=0, k<=0, out_idx++; otherwise k++.
//   - Output slots are written in order 0..35; unwritten slots keep their previous values.
//   - Accumulator width is DATA_W+W_W+4 = 44 bits, signed; it never overflows for any input.
//   - Latency: done=1 and busy=0 exactly 324 clocks after the edge that accepted start (36 x 9 MACs).
//   - start changes while in RUN are ignored; start held high after done does not re-run.
//   - A rising edge of start is needed to re-run.
//   - rst asserted mid-run aborts the run and applies full reset values, including clearing output_ram.
//   - If start is high when rst releases, the run is accepted on the first edge after release.
//   - done and busy are never both high.
// CONFIGURATION
//   CNN_CONV_SAT_EN defined:
//     result = acc clamped to [-2^31, 2^31-1], i.e. saturated into signed 32-bit.
//   CNN_CONV_SAT_EN undefined:
//     result = acc[31:0], i.e. two's-complement wrap.
//   All other behaviour is identical in both builds.
// TESTING
//   1. Ramp: img[i]=i, pulse start -> done after exactly 324 clocks; all 36 outputs = -6.
//   2. Constant: img[i]=5 -> all outputs = 0; busy high 324 cycles, then done=1 and busy=0.
//   3. Impulse: img[9]=100, others 0 -> out[1]=100 and out[7]=100; the other 34 outputs = 0.
//   4. Overflow: column 0 = 32'h7FFFFFFF, column 2 = 32'h80000000, rest 0 -> out[0], out[6] and out[12]:
//      32'h7FFFFFFF with CNN_CONV_SAT_EN; 32'hFFFFFFFD without it.
//   5. Reset mid-run: start, then assert rst at cycle 100 -> next edge: busy=0, done=0, all outputs 0;
//      a new start then gives the ramp result of test 1.
//   6. Held start: keep start=1 after done -> done stays 1 and outputs are unchanged for 500 cycles;
//      drop then re-raise start -> done=0 on the next edge, rerun completes in 324 clocks.

Source files
------------

// File: rtl/cnn_conv_engine_if.sv
// Bundles the run handshake (start/busy/done) with the image and feature-map arrays.
// The master side drives start and input_ram. The slave (engine) side drives busy, done and output_ram.
interface cnn_conv_engine_if #(
    parameter int DATA_W  = 32,
    parameter int IMG_DIM = 8,
    parameter int OUT_DIM = 6
);
    logic                     start;
    logic signed [DATA_W-1:0] input_ram  [IMG_DIM*IMG_DIM];
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] output_ram [OUT_DIM*OUT_DIM];

    modport master (
        output start,
        output input_ram,
        input  busy,
        input  done,
        input  output_ram
    );

    modport slave (
        input  start,
        input  input_ram,
        output busy,
        output done,
        output output_ram
    );
endinterface

// File: rtl/cnn_conv_engine.sv
// 3x3 valid convolution of an 8x8 signed image using one MAC per clock. Result saturation is enabled by CNN_CONV_SAT_EN.
// Latency: done rises 324 clocks after the edge that accepts start.
// No backpressure: start is edge-triggered and ignored while running, and input_ram must stay stable while busy.
module cnn_conv_engine #(
    parameter int DATA_W  = 32,
    parameter int IMG_DIM = 8,
    parameter int K_DIM   = 3,
    parameter int W_W     = 8,
    parameter logic [K_DIM*K_DIM*W_W-1:0] KERNEL = 72'hFF_00_01_FF_00_01_FF_00_01
) (
    input  logic             clk,
    input  logic             rst,
    cnn_conv_engine_if.slave bus
);
    localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
    localparam int ACC_W   = DATA_W + W_W + 4;
    localparam int RC_W    = $clog2(OUT_DIM);
    localparam int KC_W    = $clog2(K_DIM);
    localparam int PIX_W   = $clog2(IMG_DIM*IMG_DIM);
    localparam int OIDX_W  = $clog2(OUT_DIM*OUT_DIM);
    localparam int KIDX_W  = $clog2(K_DIM*K_DIM);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     start_q, start_d;
    logic [RC_W-1:0]          r_q, r_d, c_q, c_d;
    logic [KC_W-1:0]          kr_q, kr_d, kc_q, kc_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] output_ram_q [OUT_DIM*OUT_DIM];
    logic signed [DATA_W-1:0] output_ram_d [OUT_DIM*OUT_DIM];

    logic signed [W_W-1:0]    weights [K_DIM*K_DIM];
    logic [KIDX_W-1:0]        k_idx;
    logic [OIDX_W-1:0]        out_idx;
    logic [PIX_W-1:0]         pix_idx;
    logic signed [ACC_W-1:0]  pix_ext, w_ext, acc_next;
    logic signed [DATA_W-1:0] result;
    logic                     start_acc, k_last;

    for (genvar g = 0; g < K_DIM*K_DIM; g++) begin : g_weights
        assign weights[g] = KERNEL[g*W_W +: W_W];
    end

    // Window position is tracked as row/column counters so no divider is needed.
    always_comb begin
        k_idx    = KIDX_W'(int'(kr_q) * K_DIM + int'(kc_q));
        out_idx  = OIDX_W'(int'(r_q) * OUT_DIM + int'(c_q));
        pix_idx  = PIX_W'((int'(r_q) + int'(kr_q)) * IMG_DIM + int'(c_q) + int'(kc_q));
        pix_ext  = ACC_W'($signed(bus.input_ram[pix_idx]));
        w_ext    = ACC_W'(weights[k_idx]);
        acc_next = acc_q + pix_ext * w_ext;
        k_last   = (kr_q == KC_W'(K_DIM-1)) && (kc_q == KC_W'(K_DIM-1));
    end

`ifdef CNN_CONV_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        result = acc_next[DATA_W-1:0];
        if (acc_next > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (acc_next < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        result = acc_next[DATA_W-1:0];
    end
`endif

    always_comb begin
        state_d      = state_q;
        start_d      = bus.start;
        r_d          = r_q;
        c_d          = c_q;
        kr_d         = kr_q;
        kc_d         = kc_q;
        acc_d        = acc_q;
        output_ram_d = output_ram_q;
        start_acc    = bus.start && !start_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_RUN;
                    r_d     = '0;
                    c_d     = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                if (k_last) begin
                    output_ram_d[out_idx] = result;
                    acc_d = '0;
                    kr_d  = '0;
                    kc_d  = '0;
                    if (c_q == RC_W'(OUT_DIM-1)) begin
                        c_d = '0;
                        if (r_q == RC_W'(OUT_DIM-1)) begin
                            r_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_next;
                    if (kc_q == KC_W'(K_DIM-1)) begin
                        kc_d = '0;
                        kr_d = kr_q + 1'b1;
                    end else begin
                        kc_d = kc_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            acc_q   <= '0;
            for (int i = 0; i < OUT_DIM*OUT_DIM; i++) begin
                output_ram_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            r_q          <= r_d;
            c_q          <= c_d;
            kr_q         <= kr_d;
            kc_q         <= kc_d;
            acc_q        <= acc_d;
            output_ram_q <= output_ram_d;
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.output_ram = output_ram_q;
endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboard bench for cnn_conv_engine: per-run expectations come from a behavioural convolution model.
// The bench honours CNN_CONV_SAT_EN the same way as the design build.
module tb_cnn_conv_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cnn_conv_engine_if bus ();

    cnn_conv_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic signed [31:0] img [64];
    logic [31:0]        exp_q [$];
    logic [31:0]        last_exp [36];
    int                 kw [9] = '{1, 0, -1, 1, 0, -1, 1, 0, -1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input int idx);
        int     r = idx / 6;
        int     c = idx % 6;
        longint acc = 0;
        longint hi = (longint'(1) <<< 31) - 1;
        longint lo = -(longint'(1) <<< 31);
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                acc += longint'(img[(r+kr)*8 + c + kc]) * longint'(kw[kr*3 + kc]);
            end
        end
`ifdef CNN_CONV_SAT_EN
        if (acc > hi) return 32'h7FFF_FFFF;
        if (acc < lo) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    // pat: 0 ramp, 1 constant 5, 2 impulse at pixel 9, 3 column overflow
    task automatic load_img(input int pat, input bit push);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0:       img[i] = i;
                1:       img[i] = 5;
                2:       img[i] = (i == 9) ? 100 : 0;
                default: img[i] = ((i % 8) == 0) ? 32'sh7FFF_FFFF :
                                  ((i % 8) == 2) ? 32'sh8000_0000 : 0;
            endcase
            bus.input_ram[i] = img[i];
        end
        if (push) begin
            for (int i = 0; i < 36; i++) exp_q.push_back(model(i));
        end
    endtask

    // Called right after the edge that accepted start.
    task automatic run_to_done(input string name);
        int lat = 0;
        int busy_err = 0;
        logic [31:0] e;
        while (bus.done !== 1'b1 && lat < 1000) begin
            if (bus.busy !== 1'b1) busy_err++;
            tick();
            lat++;
        end
        checks++;
        if (lat == 324) passed++;
        else $display("FAIL %s latency: got %0d clocks, expected 324", name, lat);
        checks++;
        if (busy_err == 0) passed++;
        else $display("FAIL %s busy_during_run: %0d cycles low, expected 0", name, busy_err);
        checks++;
        if (bus.busy === 1'b0 && bus.done === 1'b1) passed++;
        else $display("FAIL %s end_flags: busy=%b done=%b, expected busy=0 done=1", name, bus.busy, bus.done);
        for (int i = 0; i < 36; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            last_exp[i] = e;
            checks++;
            if (bus.output_ram[i] === e) passed++;
            else $display("FAIL %s out[%0d]: got %h, expected %h", name, i, bus.output_ram[i], e);
        end
    endtask

    task automatic test_reset();
        int nz = 0;
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 36; i++) if (bus.output_ram[i] !== 32'h0) nz++;
        checks++;
        if (bus.busy === 1'b0) passed++;
        else $display("FAIL reset_busy: got %b, expected 0", bus.busy);
        checks++;
        if (bus.done === 1'b0) passed++;
        else $display("FAIL reset_done: got %b, expected 0", bus.done);
        checks++;
        if (nz == 0) passed++;
        else $display("FAIL reset_outputs: %0d nonzero slots, expected 0", nz);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pattern(input int pat, input string name);
        load_img(pat, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_to_done(name);
    endtask

    task automatic test_ramp();
        test_pattern(0, "ramp");
        checks++;
        if (bus.output_ram[35] === -32'sd6) passed++;
        else $display("FAIL ramp_direct out[35]: got %h, expected fffffffa", bus.output_ram[35]);
    endtask

    task automatic test_constant();
        test_pattern(1, "constant");
    endtask

    task automatic test_impulse();
        test_pattern(2, "impulse");
        checks++;
        if (bus.output_ram[7] === 32'sd100) passed++;
        else $display("FAIL impulse_direct out[7]: got %h, expected 00000064", bus.output_ram[7]);
    endtask

    task automatic test_overflow();
        logic [31:0] want;
`ifdef CNN_CONV_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'hFFFF_FFFD;
`endif
        test_pattern(3, "overflow");
        checks++;
        if (bus.output_ram[12] === want) passed++;
        else $display("FAIL overflow_direct out[12]: got %h, expected %h", bus.output_ram[12], want);
    endtask

    task automatic test_reset_mid_run();
        int nz = 0;
        load_img(0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (99) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 36; i++) if (bus.output_ram[i] !== 32'h0) nz++;
        checks++;
        if (bus.busy === 1'b0 && bus.done === 1'b0) passed++;
        else $display("FAIL midrun_reset_flags: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        checks++;
        if (nz == 0) passed++;
        else $display("FAIL midrun_reset_outputs: %0d nonzero slots, expected 0", nz);
        // start already high when reset releases: the first edge must accept it
        bus.start = 1'b1;
        load_img(0, 1'b1);
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy === 1'b1) passed++;
        else $display("FAIL start_at_release: busy=%b, expected 1", bus.busy);
        bus.start = 1'b0;
        run_to_done("rerun_after_reset");
    endtask

    task automatic test_held_start();
        int bad_flags = 0;
        int bad_out = 0;
        load_img(0, 1'b1);
        bus.start = 1'b1;
        tick();
        run_to_done("held_first");
        repeat (500) begin
            tick();
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) bad_flags++;
            for (int i = 0; i < 36; i++) if (bus.output_ram[i] !== last_exp[i]) bad_out++;
        end
        checks++;
        if (bad_flags == 0) passed++;
        else $display("FAIL held_flags: %0d bad cycles, expected 0", bad_flags);
        checks++;
        if (bad_out == 0) passed++;
        else $display("FAIL held_outputs: %0d changed samples, expected 0", bad_out);
        bus.start = 1'b0;
        tick();
        load_img(2, 1'b1);
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.done === 1'b0 && bus.busy === 1'b1) passed++;
        else $display("FAIL rerise_flags: done=%b busy=%b, expected 0 1", bus.done, bus.busy);
        run_to_done("held_rerun");
        bus.start = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 64; i++) bus.input_ram[i] = '0;
        test_reset();
        test_ramp();
        test_constant();
        test_impulse();
        test_overflow();
        test_reset_mid_run();
        test_held_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
